// File: rtl/pcpi_issuer.sv
// PCPI command issuer: registers one command onto the PCPI bus, waits for the coprocessor, holds its response.
// Optional timeout-to-trap logic is built when PCPI_ISSUER_TIMEOUT_EN is defined.
module pcpi_issuer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int LAT_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  // Handshake rule on cmd_* and resp_*: a transfer happens on a rising edge where valid && ready;
  // the holder of valid keeps it and its payload stable until that edge.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_insn,
  input  logic [31:0]      cmd_rs1,
  input  logic [31:0]      cmd_rs2,
  output logic             pcpi_valid,
  output logic [31:0]      pcpi_insn,
  output logic [31:0]      pcpi_rs1,
  output logic [31:0]      pcpi_rs2,
  input  logic             pcpi_wr,
  input  logic [31:0]      pcpi_rd,
  input  logic             pcpi_wait,
  input  logic             pcpi_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rd,
  output logic             resp_wr,
  output logic             resp_trap,
  output logic [LAT_W-1:0] resp_lat,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   done_ok;
  logic   timeout_hit;

  assign accept  = cmd_valid && (state == S_IDLE);
  assign done_ok = (state == S_ISSUE) && pcpi_ready;

`ifdef PCPI_ISSUER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Expiry is the TIMEOUT_CYCLES-th consecutive silent cycle; a same-cycle pcpi_ready wins.
  assign timeout_hit = (state == S_ISSUE) && !pcpi_ready && !pcpi_wait &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (state == S_ISSUE) begin
      if (pcpi_wait)
        to_cnt <= '0;
      else if (!pcpi_ready)
        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = pcpi_wait ^ (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_ISSUE;
      S_ISSUE: if (done_ok || timeout_hit) state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready  = (state == S_IDLE);
    pcpi_valid = (state == S_ISSUE);
    resp_valid = (state == S_RESP);
    dbg_state  = state;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pcpi_insn <= '0;
      pcpi_rs1  <= '0;
      pcpi_rs2  <= '0;
    end else if (accept) begin
      pcpi_insn <= cmd_insn;
      pcpi_rs1  <= cmd_rs1;
      pcpi_rs2  <= cmd_rs2;
    end
  end

  // Latency counts ISSUE cycles that end without pcpi_ready; it saturates and holds in RESP.
  always_ff @(posedge clk) begin
    if (!resetn)
      resp_lat <= '0;
    else if (accept)
      resp_lat <= '0;
    else if ((state == S_ISSUE) && !pcpi_ready && (resp_lat != {LAT_W{1'b1}}))
      resp_lat <= resp_lat + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_rd   <= '0;
      resp_wr   <= 1'b0;
      resp_trap <= 1'b0;
    end else if (done_ok) begin
      resp_rd   <= pcpi_wr ? pcpi_rd : 32'd0;
      resp_wr   <= pcpi_wr;
      resp_trap <= 1'b0;
    end else if (timeout_hit) begin
      resp_rd   <= '0;
      resp_wr   <= 1'b0;
      resp_trap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcpi_issuer.sv
// Directed self-checking bench for pcpi_issuer (default or PCPI_ISSUER_TIMEOUT_EN build).
module tb_pcpi_issuer;

  localparam int LAT_W = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_insn, cmd_rs1, cmd_rs2;
  logic             pcpi_valid;
  logic [31:0]      pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic             pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0]      pcpi_rd;
  logic             resp_valid, resp_ready;
  logic [31:0]      resp_rd;
  logic             resp_wr, resp_trap;
  logic [LAT_W-1:0] resp_lat;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  pcpi_issuer #(.TIMEOUT_CYCLES(16), .LAT_W(LAT_W)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd(resp_rd), .resp_wr(resp_wr), .resp_trap(resp_trap), .resp_lat(resp_lat),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic idle_inputs();
    cmd_valid = 0; cmd_insn = 0; cmd_rs1 = 0; cmd_rs2 = 0;
    pcpi_wr = 0; pcpi_rd = 0; pcpi_wait = 0; pcpi_ready = 0;
    resp_ready = 0;
  endtask

  // Driver: present a command at a negedge; it is accepted on the next posedge.
  task automatic send_cmd(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    @(negedge clk);
    cmd_valid = 1; cmd_insn = insn; cmd_rs1 = rs1; cmd_rs2 = rs2;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (pcpi_valid !== 1'b0) begin errors++; $display("FAIL reset_pcpi_valid got=%b exp=0", pcpi_valid); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++;
    if ({resp_rd, resp_wr, resp_trap, resp_lat, pcpi_insn, pcpi_rs1, pcpi_rs2} !== '0) begin
      errors++;
      $display("FAIL reset_regs got rd=%h wr=%b trap=%b lat=%0d insn=%h rs1=%h rs2=%h exp all zero",
               resp_rd, resp_wr, resp_trap, resp_lat, pcpi_insn, pcpi_rs1, pcpi_rs2);
    end
    resetn = 1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  // Full transaction: responder raises ready in ISSUE cycle index 'delay' (0 = first pcpi_valid cycle),
  // asserts pcpi_wait for cycle indices [wait_from, wait_from+wait_len), then the response is held
  // for 'hold' cycles before being consumed.
  task automatic do_txn(input string name, input logic [31:0] insn, input logic [31:0] rs1,
                        input logic [31:0] rs2, input int delay, input int wait_from, input int wait_len,
                        input logic wr, input logic [31:0] rd, input logic [31:0] exp_rd,
                        input int exp_lat, input int exp_vcyc, input int hold);
    int vcnt = 0, unstable = 0, early = 0;
    logic [31:0] h_rd;
    logic [LAT_W-1:0] h_lat;
    logic h_wr;
    send_cmd(insn, rs1, rs2);
    for (int k = 0; k <= delay; k++) begin
      if (pcpi_valid === 1'b1) vcnt++;
      if ({pcpi_insn, pcpi_rs1, pcpi_rs2} !== {insn, rs1, rs2}) unstable++;
      if (resp_valid !== 1'b0) early++;
      pcpi_wait = (k >= wait_from) && (k < wait_from + wait_len);
      if (k == delay) begin pcpi_ready = 1; pcpi_wr = wr; pcpi_rd = rd; pcpi_wait = 0; end
      @(negedge clk);
    end
    pcpi_ready = 0; pcpi_wr = 0; pcpi_rd = 0; pcpi_wait = 0;
    checks++; if (unstable != 0) begin errors++; $display("FAIL %s_pcpi_payload bad_cycles=%0d exp=0", name, unstable); end
    checks++; if (early != 0) begin errors++; $display("FAIL %s_early_resp cycles=%0d exp=0", name, early); end
    checks++; if (vcnt != exp_vcyc) begin errors++; $display("FAIL %s_valid_cycles got=%0d exp=%0d", name, vcnt, exp_vcyc); end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL %s_resp_valid got=%b exp=1", name, resp_valid); end
    checks++; if (pcpi_valid !== 1'b0) begin errors++; $display("FAIL %s_pcpi_drop got=%b exp=0", name, pcpi_valid); end
    checks++; if (resp_rd !== exp_rd) begin errors++; $display("FAIL %s_resp_rd got=%h exp=%h", name, resp_rd, exp_rd); end
    checks++; if (resp_wr !== wr) begin errors++; $display("FAIL %s_resp_wr got=%b exp=%b", name, resp_wr, wr); end
    checks++; if (resp_trap !== 1'b0) begin errors++; $display("FAIL %s_resp_trap got=%b exp=0", name, resp_trap); end
    checks++; if (resp_lat !== LAT_W'(exp_lat)) begin errors++; $display("FAIL %s_resp_lat got=%0d exp=%0d", name, resp_lat, exp_lat); end
    h_rd = resp_rd; h_wr = resp_wr; h_lat = resp_lat;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || cmd_ready !== 1'b0 || resp_rd !== h_rd || resp_wr !== h_wr || resp_lat !== h_lat) begin
        errors++;
        $display("FAIL %s_hold cyc=%0d got valid=%b cmd_ready=%b rd=%h lat=%0d exp valid=1 cmd_ready=0 rd=%h lat=%0d",
                 name, i, resp_valid, cmd_ready, resp_rd, resp_lat, h_rd, h_lat);
      end
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    checks++; if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s_consume got valid=%b cmd_ready=%b exp valid=0 cmd_ready=1", name, resp_valid, cmd_ready);
    end
  endtask

  task automatic test_stray_ready();
    @(negedge clk);
    pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = 32'hBAD0BAD0;
    @(negedge clk);
    pcpi_ready = 0; pcpi_wr = 0; pcpi_rd = 0;
    checks++; if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL stray_ready got valid=%b cmd_ready=%b exp valid=0 cmd_ready=1", resp_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    send_cmd(32'h02B50533, 32'd3, 32'd5);
    pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = 32'd15;
    @(negedge clk);
    pcpi_ready = 0; pcpi_wr = 0; pcpi_rd = 0;
    checks++; if (resp_rd !== 32'd15 || resp_lat !== 0) begin
      errors++; $display("FAIL b2b_first got rd=%h lat=%0d exp rd=0000000f lat=0", resp_rd, resp_lat);
    end
    // New command already waiting while the response is consumed: it must wait one IDLE cycle.
    cmd_valid = 1; cmd_insn = 32'h02B52533; cmd_rs1 = 32'hA5A5A5A5; cmd_rs2 = 32'h0F0F0F0F;
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    checks++; if (pcpi_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got pcpi_valid=%b cmd_ready=%b exp 0/1", pcpi_valid, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 0;
    checks++; if (pcpi_valid !== 1'b1 || pcpi_rs1 !== 32'hA5A5A5A5 || pcpi_insn !== 32'h02B52533) begin
      errors++; $display("FAIL b2b_second got valid=%b insn=%h rs1=%h exp 1/02b52533/a5a5a5a5", pcpi_valid, pcpi_insn, pcpi_rs1);
    end
    pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = 32'h77;
    @(negedge clk);
    pcpi_ready = 0; pcpi_wr = 0; pcpi_rd = 0;
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_end cmd_ready=%b exp=1", cmd_ready); end
  endtask

  task automatic test_no_ready();
    int k;
    send_cmd(32'h02B50533, 32'd1, 32'd1);
`ifdef PCPI_ISSUER_TIMEOUT_EN
    k = 0;
    while (resp_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k != 16) begin errors++; $display("FAIL timeout_cycles got=%0d exp=16", k); end
    checks++; if (resp_trap !== 1'b1 || resp_rd !== 0 || resp_wr !== 1'b0) begin
      errors++; $display("FAIL timeout_resp got trap=%b rd=%h wr=%b exp 1/0/0", resp_trap, resp_rd, resp_wr);
    end
    checks++; if (resp_lat !== 16) begin errors++; $display("FAIL timeout_lat got=%0d exp=16", resp_lat); end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL timeout_consume cmd_ready=%b exp=1", cmd_ready); end
`else
    k = 0;
    for (int i = 0; i < 1000; i++) begin
      if (pcpi_valid !== 1'b1 || resp_valid !== 1'b0 || resp_trap !== 1'b0) k++;
      @(negedge clk);
    end
    checks++; if (k != 0) begin errors++; $display("FAIL no_timeout bad_cycles=%0d exp=0", k); end
    checks++; if (resp_lat !== 8'hFF) begin errors++; $display("FAIL lat_saturate got=%0d exp=255", resp_lat); end
    // Recover via reset, which also covers abandoning a transaction in ISSUE.
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    checks++; if (pcpi_valid !== 1'b0 || resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL no_timeout_reset got pcpi_valid=%b resp_valid=%b cmd_ready=%b exp 0/0/1", pcpi_valid, resp_valid, cmd_ready);
    end
`endif
  endtask

  task automatic test_reset_mid_issue();
    int bad = 0;
    send_cmd(32'h02B50533, 32'd9, 32'd9);
    @(negedge clk);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    checks++; if (pcpi_valid !== 1'b0 || pcpi_insn !== 0) begin
      errors++; $display("FAIL rst_issue_pcpi got valid=%b insn=%h exp 0/0", pcpi_valid, pcpi_insn);
    end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_cmd_ready got=%b exp=1", cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = 32'h55;
      @(negedge clk);
      if (resp_valid !== 1'b0) bad++;
    end
    pcpi_ready = 0; pcpi_wr = 0; pcpi_rd = 0;
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_issue_no_resp cycles=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    // MUL 7*6, responder 2 cycles after pcpi_valid
    do_txn("mul", 32'h02B50533, 32'd7, 32'd6, 2, 99, 0, 1'b1, 32'd42, 32'd42, 2, 3, 0);
    // MULH 0x80000000*2: high word of -2^32
    do_txn("mulh", 32'h02B51533, 32'h80000000, 32'd2, 1, 99, 0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 2, 0);
    // wr=0 response: rd must be masked to zero
    do_txn("nowr", 32'h02B53533, 32'd4, 32'd4, 0, 99, 0, 1'b0, 32'hDEADBEEF, 32'd0, 0, 1, 0);
    // 40 wait cycles after the first silent cycle, then ready
    do_txn("wait", 32'h02B53533, 32'd1, 32'd2, 41, 1, 40, 1'b1, 32'h1234, 32'h1234, 41, 42, 0);
    // response held 10 cycles
    do_txn("hold", 32'h02B50533, 32'd11, 32'd12, 1, 99, 0, 1'b1, 32'd132, 32'd132, 1, 2, 10);
    test_stray_ready();
    test_back_to_back();
    test_no_ready();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
